// File: rtl/sw_credit_scheduler_if.sv
// sw_credit_scheduler_if: request, credit-return and grant bundle for one output-port scheduler
interface sw_credit_scheduler_if #(
    parameter int NUM_PORTS    = 5,
    parameter int NUM_VC       = 4,
    parameter int BUFFER_DEPTH = 8,
    parameter int NUM_REQ      = NUM_PORTS * NUM_VC,
    parameter int VC_BITS      = $clog2(NUM_VC),
    parameter int CREDIT_BITS  = $clog2(BUFFER_DEPTH + 1)
);
    logic [NUM_REQ-1:0]                  req;
    logic [NUM_REQ-1:0][VC_BITS-1:0]     req_ovc;
    logic [NUM_REQ-1:0]                  req_tail;
    logic [NUM_VC-1:0]                   credit_return;
    logic [NUM_REQ-1:0]                  grant;
    logic                                grant_valid;
    logic [VC_BITS-1:0]                  grant_ovc;
    logic                                locked;
    logic [NUM_VC-1:0][CREDIT_BITS-1:0]  credit_count;
    logic                                credit_error;

    modport master (
        output req, req_ovc, req_tail, credit_return,
        input  grant, grant_valid, grant_ovc, locked, credit_count, credit_error
    );

    modport slave (
        input  req, req_ovc, req_tail, credit_return,
        output grant, grant_valid, grant_ovc, locked, credit_count, credit_error
    );
endinterface

// File: rtl/sw_credit_scheduler.sv
// sw_credit_scheduler: credit-aware round-robin switch scheduler with packet locking for one output port
module sw_credit_scheduler #(
    parameter int NUM_PORTS    = 5,
    parameter int NUM_VC       = 4,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    sw_credit_scheduler_if.slave   bus
);
    localparam int NUM_REQ     = NUM_PORTS * NUM_VC;
    localparam int VC_BITS     = $clog2(NUM_VC);
    localparam int CREDIT_BITS = $clog2(BUFFER_DEPTH + 1);
    localparam int PTR_BITS    = $clog2(NUM_REQ);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t                              state_q, state_d;
    logic [PTR_BITS-1:0]                 ptr_q, ptr_d, owner_q, owner_d;
    logic [NUM_REQ-1:0]                  grant_q, grant_d;
    logic [VC_BITS-1:0]                  ovc_q, ovc_d;
    logic [NUM_VC-1:0][CREDIT_BITS-1:0]  credit_q, credit_d;
    logic                                err_q, err_d;
    logic [NUM_REQ-1:0]                  elig;
    logic [NUM_VC-1:0]                   dec;
    logic                                win_vld;
    logic [PTR_BITS-1:0]                 win;

    // a requester is eligible only while its output VC has downstream credit
    always_comb begin
        elig = '0;
        for (int r = 0; r < NUM_REQ; r++)
            elig[r] = bus.req[r] && (credit_q[bus.req_ovc[r]] != '0);
    end

    // pick the winner: locked owner only, else first eligible at or after the pointer (iterating down leaves the nearest)
    always_comb begin
        win_vld = 1'b0;
        win     = owner_q;
        if (state_q == LOCKED) begin
            win_vld = elig[owner_q];
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (elig[(int'(ptr_q) + i) % NUM_REQ]) begin
                    win_vld = 1'b1;
                    win     = PTR_BITS'((int'(ptr_q) + i) % NUM_REQ);
                end
            end
        end
    end

    // grant, pointer and lock state for the next cycle
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = '0;
        ovc_d   = '0;
        if (win_vld) begin
            grant_d[win] = 1'b1;
            ovc_d        = bus.req_ovc[win];
            ptr_d        = (win == PTR_BITS'(NUM_REQ - 1)) ? '0 : win + PTR_BITS'(1);
            owner_d      = win;
            state_d      = bus.req_tail[win] ? ARB : LOCKED;
        end
    end

    // downstream credits: a grant and a return on the same VC cancel; a return into a full counter is an error
    always_comb begin
        err_d    = err_q;
        dec      = '0;
        credit_d = credit_q;
        for (int v = 0; v < NUM_VC; v++) begin
            dec[v] = win_vld && (ovc_d == VC_BITS'(v));
            if (bus.credit_return[v] && !dec[v]) begin
                if (credit_q[v] == CREDIT_BITS'(BUFFER_DEPTH))
                    err_d = 1'b1;
                else
                    credit_d[v] = credit_q[v] + CREDIT_BITS'(1);
            end else if (dec[v] && !bus.credit_return[v]) begin
                credit_d[v] = credit_q[v] - CREDIT_BITS'(1);
            end
        end
    end

    // state registers; the downstream router shares this reset, so credits reload to full
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB;
            ptr_q    <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            ovc_q    <= '0;
            credit_q <= {NUM_VC{CREDIT_BITS'(BUFFER_DEPTH)}};
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            ovc_q    <= ovc_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.grant_valid  = |grant_q;
    assign bus.grant_ovc    = ovc_q;
    assign bus.locked       = (state_q == LOCKED);
    assign bus.credit_count = credit_q;
    assign bus.credit_error = err_q;
endmodule

// File: tb/tb_sw_credit_scheduler.sv
// tb_sw_credit_scheduler: directed scoreboard bench for the credit-aware switch scheduler
module tb_sw_credit_scheduler;
    localparam int NR = 20;
    localparam int NV = 4;
    localparam int BD = 8;

    typedef struct {
        int cyc;
        int idx;
        int ovc;
        int lk;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   k, m;
    exp_t q[$];

    sw_credit_scheduler_if bus ();

    sw_credit_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int c, input int idx, input int ovc, input int lk);
        exp_t e;
        e.cyc = c;
        e.idx = idx;
        e.ovc = ovc;
        e.lk  = lk;
        q.push_back(e);
    endtask

    task automatic clear_in();
        bus.req           = '0;
        bus.req_tail      = '0;
        bus.req_ovc       = '0;
        bus.credit_return = '0;
    endtask

    task automatic chk_credits(input string name, input int c0, input int c1, input int c2, input int c3);
        chk({name, " credit0"}, int'(bus.credit_count[0]), c0);
        chk({name, " credit1"}, int'(bus.credit_count[1]), c1);
        chk({name, " credit2"}, int'(bus.credit_count[2]), c2);
        chk({name, " credit3"}, int'(bus.credit_count[3]), c3);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("pending expected grants", q.size(), 0);
        chk("reset grant", int'(bus.grant), 0);
        chk("reset grant_valid", int'(bus.grant_valid), 0);
        chk("reset grant_ovc", int'(bus.grant_ovc), 0);
        chk("reset locked", int'(bus.locked), 0);
        chk("reset credit_error", int'(bus.credit_error), 0);
        chk_credits("reset", BD, BD, BD, BD);
        step(2);
        reset = 1'b1;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (reset && bus.grant_valid) begin
                    int ai;
                    ai = -1;
                    for (int b = 0; b < NR; b++)
                        if (bus.grant[b]) ai = b;
                    chk("grant onehot", $countones(bus.grant), 1);
                    if (q.size() == 0) begin
                        chk("unexpected grant idx", ai, -1);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("grant cycle", cyc, e.cyc);
                        chk("grant idx", ai, e.idx);
                        chk("grant ovc", int'(bus.grant_ovc), e.ovc);
                        chk("grant locked", int'(bus.locked), e.lk);
                    end
                end
            end
        join_none

        // all requesters on VC 0, single-flit: grants 0..7 then VC 0 runs dry
        clear_in();
        bus.req      = '1;
        bus.req_tail = '1;
        do_reset();
        k = cyc;
        for (int i = 0; i < 8; i++) expect_grant(k + 1 + i, i, 0, 0);
        step(11);
        chk_credits("drain", 0, BD, BD, BD);
        clear_in();

        // 3 and 17 alternate while returns cancel each decision's credit
        do_reset();
        k = cyc;
        bus.req[3]     = 1'b1;
        bus.req[17]    = 1'b1;
        bus.req_ovc[3] = 2'd1;
        bus.req_ovc[17] = 2'd2;
        bus.req_tail   = '1;
        for (int i = 0; i < 8; i++) expect_grant(k + 1 + i, (i % 2) ? 17 : 3, (i % 2) ? 2 : 1, 0);
        for (int j = 0; j <= 8; j++) begin
            if (j == 8) begin
                bus.req           = '0;
                bus.credit_return = '0;
            end else begin
                bus.credit_return = (j < 2) ? 4'b0000 : ((j % 2 == 0) ? 4'b0010 : 4'b0100);
            end
            @(negedge clk);
            if (j >= 2) chk_credits("alternate", BD, BD - 1, BD - 1, BD);
            step();
        end
        chk("alternate credit_error", int'(bus.credit_error), 0);
        clear_in();

        // 4-flit packet from 5 holds the port against 6
        do_reset();
        k = cyc;
        bus.req[5]      = 1'b1;
        bus.req[6]      = 1'b1;
        bus.req_ovc[6]  = 2'd3;
        bus.req_tail[6] = 1'b1;
        expect_grant(k + 1, 5, 0, 1);
        expect_grant(k + 2, 5, 0, 1);
        expect_grant(k + 3, 5, 0, 1);
        expect_grant(k + 4, 5, 0, 0);
        expect_grant(k + 5, 6, 3, 0);
        step(3);
        bus.req_tail[5] = 1'b1;
        step();
        bus.req[5] = 1'b0;
        step();
        bus.req[6] = 1'b0;
        step(3);
        clear_in();

        // owner 5 stalls for three decisions mid-packet while 9 waits
        do_reset();
        k = cyc;
        bus.req[5]      = 1'b1;
        bus.req[9]      = 1'b1;
        bus.req_ovc[9]  = 2'd1;
        bus.req_tail[9] = 1'b1;
        expect_grant(k + 1, 5, 0, 1);
        expect_grant(k + 2, 5, 0, 1);
        expect_grant(k + 6, 5, 0, 1);
        expect_grant(k + 7, 5, 0, 0);
        expect_grant(k + 8, 9, 1, 0);
        step(2);
        bus.req[5] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            if (j == 2) bus.req[5] = 1'b1;
            @(negedge clk);
            chk("stall locked", int'(bus.locked), 1);
        end
        step();
        bus.req_tail[5] = 1'b1;
        step();
        bus.req[5] = 1'b0;
        step();
        bus.req[9] = 1'b0;
        step(3);
        clear_in();

        // exhaust VC 2, then one return lets requester 0 through two cycles later
        do_reset();
        k = cyc;
        bus.req[0]      = 1'b1;
        bus.req_ovc[0]  = 2'd2;
        bus.req_tail[0] = 1'b1;
        for (int i = 0; i < 8; i++) expect_grant(k + 1 + i, 0, 2, 0);
        step(10);
        @(negedge clk);
        chk_credits("exhausted", BD, BD, 0, BD);
        step();
        bus.credit_return[2] = 1'b1;
        expect_grant(k + 13, 0, 2, 0);
        step();
        bus.credit_return[2] = 1'b0;
        @(negedge clk);
        chk("returned credit2", int'(bus.credit_count[2]), 1);
        step();
        bus.req[0] = 1'b0;
        @(negedge clk);
        chk("reconsumed credit2", int'(bus.credit_count[2]), 0);
        step();
        m = cyc;
        bus.req[4]           = 1'b1;
        bus.req_ovc[4]       = 2'd1;
        bus.req_tail[4]      = 1'b1;
        bus.credit_return[1] = 1'b1;
        expect_grant(m + 1, 4, 1, 0);
        step();
        clear_in();
        @(negedge clk);
        chk_credits("cancel", BD, BD, 0, BD);
        chk("cancel credit_error", int'(bus.credit_error), 0);
        step(2);

        // return into a full counter saturates and sets the sticky error; reset mid-lock clears it
        do_reset();
        bus.credit_return[0] = 1'b1;
        step();
        bus.credit_return[0] = 1'b0;
        @(negedge clk);
        chk("overflow credit0", int'(bus.credit_count[0]), BD);
        chk("overflow credit_error", int'(bus.credit_error), 1);
        step(2);
        @(negedge clk);
        chk("sticky credit_error", int'(bus.credit_error), 1);
        step();
        k = cyc;
        bus.req[2]     = 1'b1;
        bus.req_ovc[2] = 2'd3;
        expect_grant(k + 1, 2, 3, 1);
        step();
        bus.req[2] = 1'b0;
        @(negedge clk);
        chk("midlock locked", int'(bus.locked), 1);
        chk("midlock credit3", int'(bus.credit_count[3]), BD - 1);
        do_reset();
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
